seg_scroll_decoder: RTL
=======================

Name: seg_scroll_decoder

Overview:
- Receive-side counterpart of the scrolling "HELLO" 7-segment display driver.
- Watches the pNO_LED x 8-bit segment bus the driver produces and detects each scroll step.
- Checks that every new frame is the previous frame shifted by one digit, and decodes the newly entered digit back to ASCII.
- Buffers decoded characters in a small FIFO with a valid/ready handshake; used as an in-system checker and as a bench scoreboard front-end.

Parameters:
- pNO_LED, 8, number of 7-segment digits on the bus (>=2)
- pFIFO_DEPTH, 4, output character FIFO depth (power of 2, >=2)
- pCNT_W, 8, width of the saturating scroll-error counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  sample enable; low freezes sampling and the FSM, FIFO pop still allowed
- LED_IN  in  [pNO_LED-1:0][7:0]  segment bus, per digit {dp,g,f,e,d,c,b,a}, active-high
- char_ready  in  1  consumer accepts char_out this cycle
- char_valid  out  1  FIFO non-empty
- char_out  out  8  ASCII code at FIFO head
- locked  out  1  scroll sequence verified (FSM in LOCKED)
- scroll_err  out  1  one-cycle pulse: frame change not a valid shift while LOCKED
- seg_err  out  1  one-cycle pulse: entering digit has an undecodable pattern
- overflow  out  1  sticky: character dropped because FIFO full
- err_cnt  out  pCNT_W  saturating count of scroll_err pulses

Behaviour:
- Reset values:
  - all outputs 0
  - FIFO empty
  - FSM in IDLE
  - ref frame and sampled frame all 0x00
- Input stage:
  - LED_IN is registered into led_q every cycle en=1; held when en=0.
- Frame event:
  - Raised when en=1 and led_q != ref, with dp bits masked (see optional feature).
  - No event when they are equal.
- Shift-valid test:
  - led_q[k+1] == ref[k] for all k = 0..pNO_LED-2.
  - Content moves toward the higher index; the new character enters at index 0.
- Decode of led_q[0][6:0]:
  - 0x76->'H'(0x48)
  - 0x79->'E'(0x45)
  - 0x38->'L'(0x4C)
  - 0x3F->'O'(0x4F)
  - 0x50->'R'(0x52)
  - 0x5E->'D'(0x44)
  - 0x00->' '(0x20)
  - anything else->'?'(0x3F), with a seg_err pulse
- FSM IDLE:
  - Goes to ACQ when en=1, after loading ref <= led_q.
- FSM ACQ:
  - On event with shift-valid: go to LOCKED and push the decoded char.
  - On event without shift-valid: stay in ACQ, no push, no scroll_err.
  - ref <= led_q on every event.
- FSM LOCKED:
  - On event with shift-valid: push the decoded char and stay in LOCKED.
  - On event without shift-valid: go to ACQ, pulse scroll_err, increment err_cnt (saturating at all-ones), no push.
  - ref <= led_q on every event.
- Latency:
  - LED_IN change sampled at edge t.
  - Evaluation and push at edge t+1.
  - char_valid high and scroll_err/seg_err pulses visible after edge t+1.
- FIFO:
  - First-word fall-through; pop when char_valid & char_ready.
  - Push while full with a simultaneous pop is accepted.
  - Push while full without a pop drops the char and sets overflow (sticky until rst).
  - Pop while empty is ignored.
- en=0: FSM, ref and led_q hold; no events are raised.
- rst mid-operation: synchronous reset to the reset values on the next edge, overriding everything including a same-cycle push or pop.
- locked = (state == LOCKED).

Optional Feature:
- Macro SEG_DP_CHECK_EN.
- When defined:
  - the dp bit (bit 7) is included in the event and shift-valid comparisons
  - char_out[7] carries the dp bit of the entering digit; decode still uses bits [6:0]
- When undefined:
  - dp is masked to 0 in all comparisons
  - char_out[7] is always 0

Test Plan:
- Reset, then en=1 with LED_IN all 0x00 for 10 cycles -> state ACQ, locked=0, char_valid=0, err_cnt=0.
- From an all-blank frame, set LED_IN[0]=0x76, then hold stable -> locked=1, char_out=0x48, char_valid high 2 edges after the change; exactly one push.
- Drive frames H, HE, HEL, HELL, HELLO, HELLO+blank, each held 5 cycles, char_ready=1 -> output stream 0x48,0x45,0x4C,0x4C,0x4F,0x20; scroll_err never pulses.
- While LOCKED, jump to a frame with LED_IN[3] changed without a shift -> scroll_err one-cycle pulse, err_cnt=1, locked=0, no push. The next valid shift relocks.
- char_ready=0 with 5 valid shifts, pFIFO_DEPTH=4 -> 4 chars held, overflow=1. Release ready -> the first 4 chars drain in order, overflow stays 1 until rst.
- Entering digit 0x49 on a valid shift -> char_out=0x3F, seg_err pulse; with SEG_DP_CHECK_EN, digit 0xF6 -> char_out=0xC8.

Source files
------------

// File: rtl/seg_scroll_decoder_if.sv
// Character stream handshake between the scroll decoder and its consumer.
interface seg_scroll_if;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_out;

    modport master (output char_valid, output char_out, input char_ready);
    modport slave  (input char_valid, input char_out, output char_ready);
endinterface

// File: rtl/seg_scroll_decoder.sv
// Watches a scrolling 7-segment bus, verifies each step is a one-digit shift and
// queues the decoded entering character. Optional macro SEG_DP_CHECK_EN adds the dp bit.
module seg_scroll_decoder #(
    parameter int pNO_LED     = 8,
    parameter int pFIFO_DEPTH = 4,
    parameter int pCNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [pNO_LED-1:0][7:0] LED_IN,
    seg_scroll_if.master            ch,
    output logic                    locked,
    output logic                    scroll_err,
    output logic                    seg_err,
    output logic                    overflow,
    output logic [pCNT_W-1:0]       err_cnt
);

    localparam int AW = $clog2(pFIFO_DEPTH);
`ifdef SEG_DP_CHECK_EN
    localparam logic [7:0] DP_MASK = 8'hFF;
`else
    localparam logic [7:0] DP_MASK = 8'h7F;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

    state_t                    state_q, state_d;
    logic [pNO_LED-1:0][7:0]   led_q, led_d;
    logic [pNO_LED-1:0][7:0]   ref_q, ref_d;
    logic                      scroll_err_q, scroll_err_d;
    logic                      seg_err_q, seg_err_d;
    logic                      overflow_q, overflow_d;
    logic [pCNT_W-1:0]         err_cnt_q, err_cnt_d;
    logic [7:0]                mem_q [pFIFO_DEPTH];
    logic [7:0]                mem_d [pFIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]               cnt_q, cnt_d;

    logic       frame_evt, shift_ok, frame_diff;
    logic       dec_bad, push, pop, push_ok, full, empty;
    logic [6:0] dec_ascii;
    logic [7:0] dec_char;

    always_comb begin
        led_d = en ? LED_IN : led_q;
    end

    // Compare against the last accepted frame; dp is masked unless the check is enabled.
    always_comb begin
        shift_ok   = 1'b1;
        frame_diff = 1'b0;
        for (int k = 0; k < pNO_LED; k++) begin
            if ((led_q[k] & DP_MASK) != (ref_q[k] & DP_MASK))
                frame_diff = 1'b1;
        end
        for (int k = 0; k < pNO_LED - 1; k++) begin
            if ((led_q[k+1] & DP_MASK) != (ref_q[k] & DP_MASK))
                shift_ok = 1'b0;
        end
        frame_evt = en & frame_diff;
    end

    always_comb begin
        dec_bad = 1'b0;
        case (led_q[0][6:0])
            7'h76:   dec_ascii = 7'h48;
            7'h79:   dec_ascii = 7'h45;
            7'h38:   dec_ascii = 7'h4C;
            7'h3F:   dec_ascii = 7'h4F;
            7'h50:   dec_ascii = 7'h52;
            7'h5E:   dec_ascii = 7'h44;
            7'h00:   dec_ascii = 7'h20;
            default: begin
                dec_ascii = 7'h3F;
                dec_bad   = 1'b1;
            end
        endcase
`ifdef SEG_DP_CHECK_EN
        dec_char = {led_q[0][7], dec_ascii};
`else
        dec_char = {1'b0, dec_ascii};
`endif
    end

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        push         = 1'b0;
        scroll_err_d = 1'b0;
        seg_err_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    ref_d   = led_q;
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                if (frame_evt) begin
                    ref_d = led_q;
                    if (shift_ok) begin
                        state_d   = S_LOCKED;
                        push      = 1'b1;
                        seg_err_d = dec_bad;
                    end
                end
            end
            S_LOCKED: begin
                if (frame_evt) begin
                    ref_d = led_q;
                    if (shift_ok) begin
                        push      = 1'b1;
                        seg_err_d = dec_bad;
                    end else begin
                        state_d      = S_ACQ;
                        scroll_err_d = 1'b1;
                        if (err_cnt_q != {pCNT_W{1'b1}})
                            err_cnt_d = err_cnt_q + pCNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FWFT FIFO: a push into a full FIFO survives only if the head leaves the same cycle.
    always_comb begin
        full       = (cnt_q == (AW+1)'(pFIFO_DEPTH));
        empty      = (cnt_q == '0);
        pop        = !empty && ch.char_ready;
        push_ok    = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);
        mem_d      = mem_q;
        if (push_ok)
            mem_d[wr_ptr_q] = dec_char;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            led_q        <= '0;
            ref_q        <= '0;
            scroll_err_q <= 1'b0;
            seg_err_q    <= 1'b0;
            overflow_q   <= 1'b0;
            err_cnt_q    <= '0;
            for (int i = 0; i < pFIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            led_q        <= led_d;
            ref_q        <= ref_d;
            scroll_err_q <= scroll_err_d;
            seg_err_q    <= seg_err_d;
            overflow_q   <= overflow_d;
            err_cnt_q    <= err_cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ch.char_valid = !empty;
    assign ch.char_out   = mem_q[rd_ptr_q];
    assign locked        = (state_q == S_LOCKED);
    assign scroll_err    = scroll_err_q;
    assign seg_err       = seg_err_q;
    assign overflow      = overflow_q;
    assign err_cnt       = err_cnt_q;

endmodule
